// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM burst controller.
package vram_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned AddrWDefault = 16;

  typedef logic [DataWDefault-1:0] vram_word_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait
  } vram_state_e;

endpackage

// File: rtl/vram_shadow_regs.sv
// DEPTH x DATA_W register file: async clear, one write port, combinational read.
module vram_shadow_regs #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next-state of the array: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range indices (non power-of-two DEPTH) read as zero.
  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/vram_burst_ctrl.sv
// Burst controller between game logic and the SDRAM FIFO bridge.
// vs rising edge streams DEPTH source words to the write FIFO; frame_start reads
// DEPTH words back into a shadow register file for the colour mapper.
// Optional feature macro: VRAM_READBACK_CHECK_EN keeps a golden copy of written
// words and flags a sticky mismatch on readback.
module vram_burst_ctrl
  import vram_pkg::*;
#(
  parameter int unsigned       DATA_W  = DataWDefault,
  parameter int unsigned       ADDR_W  = AddrWDefault,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [ADDR_W-1:0] WR_BASE = '0,
  parameter logic [ADDR_W-1:0] RD_BASE = '0,
  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs,
  input  logic              frame_start,
  output logic [IDX_W-1:0]  src_idx,
  input  logic [DATA_W-1:0] src_data,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [DATA_W-1:0] writedata,
  input  logic              wr_full,
  output logic              read,
  output logic [ADDR_W-1:0] readaddr,
  input  logic [DATA_W-1:0] readdata,
  input  logic              rd_empty,
  input  logic [IDX_W-1:0]  shadow_idx,
  output logic [DATA_W-1:0] shadow_data,
  output logic              busy,
  output logic              frame_done,
  output logic              mismatch
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  vram_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              vs_q;
  logic              rd_pend_q, rd_pend_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] writeaddr_q, writeaddr_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] readaddr_q, readaddr_d;
  logic              frame_done_q, frame_done_d;
  logic              mismatch_q, mismatch_d;
  logic              shadow_we;
  logic              vs_rise;

  assign vs_rise = vs & ~vs_q;

  // Next-state, request strobes and shadow write enable.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_pend_d    = rd_pend_q;
    write_d      = 1'b0;
    writeaddr_d  = writeaddr_q;
    writedata_d  = writedata_q;
    read_d       = 1'b0;
    readaddr_d   = readaddr_q;
    frame_done_d = 1'b0;
    shadow_we    = 1'b0;
    case (state_q)
      StIdle: begin
        if (vs_rise) begin
          state_d = StWrReq;
          idx_d   = '0;
          // Write wins a tie; remember the read for after the burst.
          if (frame_start) rd_pend_d = 1'b1;
        end else if (rd_pend_q || frame_start) begin
          state_d = StRdReq;
          idx_d   = '0;
        end
      end
      StWrReq: begin
        write_d     = 1'b1;
        writeaddr_d = WR_BASE + ADDR_W'(idx_q);
        writedata_d = src_data;
        if (frame_start) rd_pend_d = 1'b1;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (frame_start) rd_pend_d = 1'b1;
        if (!wr_full) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = (rd_pend_q || frame_start) ? StRdReq : StIdle;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StWrReq;
          end
        end
      end
      StRdReq: begin
        read_d     = 1'b1;
        readaddr_d = RD_BASE + ADDR_W'(idx_q);
        state_d    = StRdWait;
      end
      StRdWait: begin
        if (!rd_empty) begin
          shadow_we = 1'b1;
          if (idx_q == LastIdx) begin
            frame_done_d = 1'b1;
            rd_pend_d    = 1'b0;
            idx_d        = '0;
            state_d      = StIdle;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef VRAM_READBACK_CHECK_EN
  logic              golden_we;
  logic [DATA_W-1:0] golden_rdata;

  assign golden_we = (state_q == StWrReq);

  vram_shadow_regs #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_golden (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (golden_we),
    .waddr_i (idx_q),
    .wdata_i (src_data),
    .raddr_i (idx_q),
    .rdata_o (golden_rdata)
  );

  // Sticky compare of each captured word against what was written at that index.
  always_comb begin
    mismatch_d = mismatch_q;
    if ((state_q == StRdWait) && !rd_empty && (WR_BASE == RD_BASE) &&
        (readdata != golden_rdata)) begin
      mismatch_d = 1'b1;
    end
  end
`else
  // Readback check absent: mismatch never asserts.
  always_comb begin
    mismatch_d = 1'b0;
  end
`endif

  // State and registered outputs; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      vs_q         <= 1'b0;
      rd_pend_q    <= 1'b0;
      write_q      <= 1'b0;
      writeaddr_q  <= '0;
      writedata_q  <= '0;
      read_q       <= 1'b0;
      readaddr_q   <= '0;
      frame_done_q <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vs_q         <= vs;
      rd_pend_q    <= rd_pend_d;
      write_q      <= write_d;
      writeaddr_q  <= writeaddr_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      readaddr_q   <= readaddr_d;
      frame_done_q <= frame_done_d;
      mismatch_q   <= mismatch_d;
    end
  end

  vram_shadow_regs #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (shadow_we),
    .waddr_i (idx_q),
    .wdata_i (readdata),
    .raddr_i (shadow_idx),
    .rdata_o (shadow_data)
  );

  assign src_idx    = idx_q;
  assign write      = write_q;
  assign writeaddr  = writeaddr_q;
  assign writedata  = writedata_q;
  assign read       = read_q;
  assign readaddr   = readaddr_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign mismatch   = mismatch_q;

endmodule
